// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch top level and its next-pc helper.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        KILL
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_BRANCH
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next fetch address selection: hold, sequential +4 or taken-branch target.
// Purely combinational; all additions wrap modulo 2^32.
module pc_next
    import fetch_pkg::*;
(
    input  pc_sel_t         sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] next
);

    always_comb begin
        next = pc;
        unique case (sel)
            PC_SEQ:    next = addr + 32'd4;
            PC_BRANCH: next = base + offset;
            default:   next = pc;
        endcase
    end

endmodule

// File: rtl/fetch.sv
// Single-outstanding-request instruction fetch with a one-entry buffer.
// Requests launch combinationally from IDLE so a same-cycle ack gives 1 IPC.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] ImmOp
);

    state_t          state;
    state_t          state_nx;
    pc_sel_t         sel;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] req_addr;
    logic            consume;
    logic            redirect;
    logic            launch;
    logic            live;
    logic            ack;
    logic            keep;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A redirect in the launch cycle turns that request into a kill.
    always_comb begin
        consume   = instr_valid && instr_ready;
        redirect  = consume && PCsrc;
        launch    = (state == IDLE) && (!instr_valid || consume);
        live      = (state != IDLE) || launch;
        ack       = live && imem_ack;
        keep      = ((state == BUSY) || launch) && !redirect;
        imem_req  = live && !rst;
        imem_addr = (state == IDLE) ? pc : req_addr;
        state_nx  = state;
        sel       = PC_HOLD;
        if (ack)                   state_nx = IDLE;
        else if (live && redirect) state_nx = KILL;
        else if (launch)           state_nx = BUSY;
        if (redirect)              sel = PC_BRANCH;
        else if (ack && keep)      sel = PC_SEQ;
    end

    pc_next u_pc_next (
        .sel    (sel),
        .pc     (pc),
        .addr   (imem_addr),
        .base   (instr_pc),
        .offset (ImmOp),
        .next   (pc_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            pc <= pc_nx;
            if (launch) req_addr <= pc;
            if (ack && keep) begin
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch unit; memory returns addr ^ 32'hC0DE_0000.
// Inputs change 1ns after each rising edge, outputs are checked 1ns later.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

    fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic a, input logic rd,
                        input logic br, input logic [31:0] imm);
        @(posedge clk);
        #1;
        rst         = r;
        imem_ack    = a;
        instr_ready = rd;
        PCsrc       = br;
        ImmOp       = imm;
        #1;
    endtask

    initial begin
        // reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // back-to-back stream from RESET_PC
        step(0, 1, 1, 0, 0);
        chk("b2b_req0", 32'(imem_req), 32'd1);
        chk("b2b_addr0", imem_addr, 32'h100);
        step(0, 1, 1, 0, 0);
        chk("b2b_addr1", imem_addr, 32'h104);
        chk("b2b_ipc0", instr_pc, 32'h100);
        chk("b2b_instr0", instr, 32'hC0DE_0100);
        step(0, 1, 1, 0, 0);
        chk("b2b_addr2", imem_addr, 32'h108);
        chk("b2b_ipc1", instr_pc, 32'h104);

        // decode stall with the buffer full
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_ipc", instr_pc, 32'h108);
            chk("stall_instr", instr, 32'hC0DE_0108);
        end
        step(0, 0, 1, 0, 0);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h10C);
        step(0, 1, 1, 0, 0);
        chk("busy_valid", 32'(instr_valid), 32'd0);
        chk("busy_addr", imem_addr, 32'h10C);

        // redirect to 0x400 with the launch acked in the same cycle
        step(0, 1, 1, 1, 32'h0000_02F4);
        chk("rd_ipc", instr_pc, 32'h10C);
        chk("rd_launch", imem_addr, 32'h110);
        step(0, 1, 1, 0, 0);
        chk("rd_drop_valid", 32'(instr_valid), 32'd0);
        chk("rd_target", imem_addr, 32'h400);
        step(0, 1, 1, 1, 32'hFFFF_FE00);
        chk("rd_ipc400", instr_pc, 32'h400);
        chk("rd_instr400", instr, 32'hC0DE_0400);
        step(0, 1, 1, 0, 0);
        chk("to200_addr", imem_addr, 32'h200);

        // redirect from 0x200 while the fetch of 0x204 stays pending
        step(0, 0, 1, 1, 32'hFFFF_FFF0);
        chk("kill_ipc", instr_pc, 32'h200);
        chk("kill_launch", imem_addr, 32'h204);
        step(0, 0, 1, 0, 0);
        chk("kill_hold_addr", imem_addr, 32'h204);
        chk("kill_valid0", 32'(instr_valid), 32'd0);
        step(0, 0, 1, 0, 0);
        chk("kill_hold_req", 32'(imem_req), 32'd1);
        step(0, 1, 1, 0, 0);
        chk("kill_ack_addr", imem_addr, 32'h204);
        step(0, 0, 1, 0, 0);
        chk("kill_valid1", 32'(instr_valid), 32'd0);
        chk("kill_next", imem_addr, 32'h1F0);
        step(0, 1, 1, 0, 0);
        chk("kill_next_hold", imem_addr, 32'h1F0);

        // wrap from 0xFFFF_FFFC
        step(0, 1, 1, 1, 32'hFFFF_FE0C);
        chk("wr_ipc", instr_pc, 32'h1F0);
        step(0, 1, 1, 0, 0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0);
        chk("wr_ipc_top", instr_pc, 32'hFFFF_FFFC);
        chk("wr_instr_top", instr, 32'h3F21_FFFC);
        chk("wr_next", imem_addr, 32'h0000_0000);

        // reset while the request to 0 is outstanding
        step(1, 0, 1, 0, 0);
        chk("rb_req", 32'(imem_req), 32'd0);
        step(1, 1, 1, 0, 0);
        chk("rb_req2", 32'(imem_req), 32'd0);
        chk("rb_valid", 32'(instr_valid), 32'd0);
        step(0, 0, 1, 0, 0);
        chk("rb_valid_after", 32'(instr_valid), 32'd0);
        chk("rb_first_addr", imem_addr, 32'h100);
        step(0, 1, 1, 0, 0);
        chk("rb_hold_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 0);
        chk("rb_ipc", instr_pc, 32'h100);
        chk("rb_instr", instr, 32'hC0DE_0100);
        chk("rb_valid_end", 32'(instr_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: a fetch request is outstanding.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: the byte address of the outstanding fetch.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: the request completes this cycle; ignored while imem_req=0.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: the instruction word, valid only with imem_ack.
REQ-008 The block SHALL have port instr, output, 32 bits: the buffered instruction driven to the control unit (Op=instr[6:0], funct3=instr[14:12], funct7_5=instr[30]).
REQ-009 The block SHALL have port instr_pc, output, 32 bits: the address of instr.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr and instr_pc hold a live instruction.
REQ-011 The block SHALL have port instr_ready, input, 1 bit: decode accepts instr this cycle.
REQ-012 The block SHALL have port PCsrc, input, 1 bit: the consumed instruction is a taken branch.
REQ-013 The block SHALL have port ImmOp, input, 32 bits: the sign-extended branch offset accompanying PCsrc.

Function
REQ-014 A consume event SHALL occur when instr_valid=1 and instr_ready=1; PCsrc and ImmOp SHALL be sampled only in that cycle.
REQ-015 Request FSM states: IDLE (no request), BUSY (request live, result kept), KILL (request live, result discarded).
REQ-016 IDLE->BUSY when the buffer is empty or a consume occurs this cycle; imem_req=1 and imem_addr=pc from that cycle onward.
REQ-017 imem_req and imem_addr SHALL stay stable until the ack cycle; ack in the first req cycle is legal.
REQ-018 BUSY with ack: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=imem_addr+4 (mod 2^32); next state IDLE.
REQ-019 A consume with PCsrc=1 SHALL set pc<=instr_pc+ImmOp (mod 2^32, no alignment check) and instr_valid<=0, and SHALL move BUSY->KILL.
REQ-020 KILL with ack: data dropped, instr_valid unchanged; next state IDLE.
REQ-021 If a redirecting consume and an ack occur in the same cycle, that ack's data SHALL be dropped and the next request SHALL target the branch target.
REQ-022 A consume with PCsrc=0 and no same-cycle ack SHALL clear instr_valid.
REQ-023 At most one request outstanding and one instruction buffered; back-to-back throughput SHALL reach one instruction per cycle when the memory acks in the request cycle.
REQ-024 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-025 On rst=1: state IDLE, pc=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, imem_req=0 in the same cycle.
REQ-026 rst during BUSY/KILL SHALL abandon the request without waiting for ack; an ack after reset release is ignored unless a new request has been issued.

Structure
REQ-027 Package fetch_pkg SHALL hold the FSM state enum, the NOP constant, and the 32-bit address width constant.
REQ-028 One sub-module pc_next SHALL compute the next pc (seq +4, branch target, hold) combinationally.

Verification
REQ-029 Reset with RESET_PC=0x100 and the memory acking at once, ready=1 -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; instr_pc follows one cycle later.
REQ-030 Consume at instr_pc=0x200 with PCsrc=1, ImmOp=0xFFFF_FFF0 while the fetch of 0x204 is pending (ack 3 cycles later) -> 0x204 data never valid; next imem_addr=0x1F0.
REQ-031 Redirect consume and ack in the same cycle (target 0x400) -> that data dropped; next request 0x400.
REQ-032 instr_ready=0 for 5 cycles with buffer full -> imem_req=0, instr/instr_pc stable; fetch resumes on the consume cycle.
REQ-033 Fetch at 0xFFFF_FFFC acked -> next imem_addr 0x0000_0000.
REQ-034 rst asserted during BUSY with ack delayed -> imem_req=0 next cycle, instr_valid=0, stray ack ignored, first fetch RESET_PC.
